// File: rtl/nios_memchk_pkg.sv
// Shared definitions for the memory-check master: FSM state encoding and the
// error counter width/saturation value.
package nios_memchk_pkg;

    localparam int unsigned ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/nios_memchk_cmp.sv
// Read-data checker. Captures the expected word and its address together with
// each read command, compares against the RAM's read data one cycle later and
// keeps a saturating mismatch count plus the address of the first mismatch.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   clear                zero the count and first-fail address (run start)
//   chk_valid            a read command is on the bus this cycle
//   chk_data, chk_addr   expected data / address of that read
//   rdata                RAM read data (valid the cycle after the read)
//   err_count, fail_addr registered results
module nios_memchk_cmp
    import nios_memchk_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              chk_valid,
    input  logic [DATA_W-1:0] chk_data,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] rdata,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic              mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            exp_q   <= exp_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // A zero count means no mismatch yet this run, so it doubles as the first-fail flag.
    always_comb begin
        valid_d  = chk_valid;
        exp_d    = chk_data;
        addr_d   = chk_addr;
        err_d    = err_q;
        fail_d   = fail_q;
        mismatch = valid_q && (rdata != exp_q);
        if (clear) begin
            err_d  = '0;
            fail_d = '0;
        end else if (mismatch) begin
            if (err_q == '0) begin
                fail_d = addr_q;
            end
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: rtl/nios_mem_check_master.sv
// Avalon-MM memory test master for a single-port on-chip RAM (read latency 1,
// no waitrequest). On start it writes pattern seed+index to num_words words
// from base_addr, reads them back, and reports mismatch count, first failing
// address and a pass flag.
// Optional feature: define MEMCHK_INVERT_PASS_EN to append a second
// write/read pass using the inverted pattern ~(seed+index).
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, base_addr, num_words, seed   run request and its parameters
//   busy, done, pass, err_count, fail_addr   status
//   avm_*                        Avalon-MM master signals
module nios_mem_check_master
    import nios_memchk_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   num_words,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_clken,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_acc;
    logic              last;
    logic              inv_cur, inv_nxt;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] i,
                                                  input logic inv);
        logic [DATA_W-1:0] p;
        p = s + DATA_W'(i);
        return inv ? ~p : p;
    endfunction

`ifdef MEMCHK_INVERT_PASS_EN
    logic inv_q, inv_d;
    logic gap_q, gap_d;
    assign inv_cur = inv_q;
    assign inv_nxt = inv_d;
`else
    assign inv_cur = 1'b0;
    assign inv_nxt = 1'b0;
`endif

    assign start_acc = (state_q == ST_IDLE) && start;
    assign last      = (idx_q == num_q - ADDR_W'(1));

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            num_q   <= '0;
            seed_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEMCHK_INVERT_PASS_EN
            inv_q   <= 1'b0;
            gap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            num_q   <= num_d;
            seed_q  <= seed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEMCHK_INVERT_PASS_EN
            inv_q   <= inv_d;
            gap_q   <= gap_d;
`endif
        end
    end

    // Next-state and word-index sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        num_d   = num_q;
        seed_d  = seed_q;
`ifdef MEMCHK_INVERT_PASS_EN
        inv_d   = inv_q;
        gap_d   = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_words;
                    seed_d  = seed;
                    idx_d   = '0;
`ifdef MEMCHK_INVERT_PASS_EN
                    inv_d   = 1'b0;
                    gap_d   = 1'b0;
`endif
                    state_d = (num_words == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_READ: begin
                if (last) begin
                    idx_d   = '0;
                    state_d = ST_FLUSH;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
`ifdef MEMCHK_INVERT_PASS_EN
                // One idle flush cycle separates the two passes.
                if (!inv_q) begin
                    if (!gap_q) begin
                        gap_d = 1'b1;
                    end else begin
                        gap_d   = 1'b0;
                        inv_d   = 1'b1;
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        cs_d    = (state_d == ST_WRITE) || (state_d == ST_READ);
        wr_d    = (state_d == ST_WRITE);
        addr_d  = cs_d ? (base_d + idx_d) : '0;
        wdata_d = wr_d ? pattern(seed_d, idx_d, inv_nxt) : '0;
        pass_d  = pass_q;
        if (start_acc) begin
            pass_d = 1'b0;
        end else if (state_q == ST_DONE) begin
            pass_d = (err_count == '0);
        end
    end

    nios_memchk_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_acc),
        .chk_valid (state_q == ST_READ),
        .chk_data  (pattern(seed_q, idx_q, inv_cur)),
        .chk_addr  (addr_q),
        .rdata     (avm_readdata),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_nios_mem_check_master.sv
// Bench for nios_mem_check_master: behavioural RAM slave, a timeline model of
// the expected bus/status activity checked every cycle, and literal checks on
// the directed scenarios.
module tb_nios_mem_check_master;

`ifdef MEMCHK_INVERT_PASS_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] num_words;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [12:0] fail_addr;
    logic [12:0] avm_address;
    logic        avm_chipselect, avm_write, avm_clken;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;

    nios_mem_check_master #(.ADDR_W(13), .DATA_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .fail_addr      (fail_addr),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_clken      (avm_clken),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM slave with optional single-bit corruption on read of one address.
    logic [31:0] mem [0:8191];
    logic        corrupt_en = 1'b0;
    logic [12:0] corrupt_addr = 13'h0;
    always @(posedge clk) begin
        if (avm_chipselect && avm_write)
            mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write)
            avm_readdata <= mem[avm_address] ^ ((corrupt_en && avm_address == corrupt_addr) ? 32'h1 : 32'h0);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of the current run.
    bit          m_active = 1'b0;
    bit          run_finished = 1'b0;
    int          m_start_cyc, m_n, m_done_t, m_errs;
    logic [12:0] m_base, m_fail;
    logic [31:0] m_seed;
    int          done_seen_t;
    logic [12:0] wa_log[$];
    logic [31:0] wd_log[$];

    // Expected bus activity derived from elapsed cycles since the start cycle.
    always @(negedge clk) begin : mon
        int t, s, u, ix;
        bit e_cs, e_wr;
        logic [12:0] e_addr;
        logic [31:0] e_wd;
        if (m_active) begin
            t = cyc - m_start_cyc;
            if (t >= 1) begin
                e_cs = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
                if (m_n > 0) begin
                    for (int p = 0; p <= (INV ? 1 : 0); p++) begin
                        s = 1 + p * (2 * m_n + 2);
                        u = t - s;
                        if (u >= 0 && u < 2 * m_n) begin
                            e_cs   = 1'b1;
                            e_wr   = (u < m_n);
                            ix     = e_wr ? u : u - m_n;
                            e_addr = 13'(m_base + 13'(ix));
                            e_wd   = m_seed + 32'(ix);
                            if (p == 1) e_wd = ~e_wd;
                        end
                    end
                end
                chk("chipselect", 32'(avm_chipselect), 32'(e_cs));
                chk("write", 32'(avm_write), 32'(e_wr));
                chk("busy", 32'(busy), 32'(t <= m_done_t));
                chk("done", 32'(done), 32'(t == m_done_t));
                chk("clken", 32'(avm_clken), 32'h1);
                if (e_cs) chk("address", 32'(avm_address), 32'(e_addr));
                if (e_wr) begin
                    chk("writedata", avm_writedata, e_wd);
                    chk("byteenable", 32'(avm_byteenable), 32'hF);
                    wa_log.push_back(avm_address);
                    wd_log.push_back(avm_writedata);
                end
                if (done && done_seen_t < 0) done_seen_t = t;
                if (t <= m_done_t) chk("pass_low_in_run", 32'(pass), 32'h0);
                if (t == m_done_t) begin
                    chk("err_count", 32'(err_count), 32'(m_errs));
                    if (m_errs > 0) chk("fail_addr", 32'(fail_addr), 32'(m_fail));
                end
                if (t == m_done_t + 1) begin
                    chk("pass", 32'(pass), 32'(m_errs == 0));
                    m_active     = 1'b0;
                    run_finished = 1'b1;
                end
            end
        end
    end

    task automatic run(input logic [12:0] b, input logic [12:0] n, input logic [31:0] s, input bit dup_start);
        logic [12:0] a;
        @(negedge clk);
        base_addr = b; num_words = n; seed = s; start = 1'b1;
        m_base = b; m_n = int'(n); m_seed = s;
        m_done_t = (n == 0) ? 1 : (INV ? 4 * int'(n) + 4 : 2 * int'(n) + 2);
        m_errs = 0; m_fail = '0;
        for (int p = 0; p < ((n == 0) ? 0 : (INV ? 2 : 1)); p++) begin
            for (int i = 0; i < int'(n); i++) begin
                a = 13'(b + 13'(i));
                if (corrupt_en && a == corrupt_addr) begin
                    if (m_errs == 0) m_fail = a;
                    m_errs++;
                end
            end
        end
        wa_log.delete(); wd_log.delete();
        done_seen_t  = -1;
        run_finished = 1'b0;
        m_start_cyc  = cyc;
        m_active     = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = 13'h0ABC; num_words = 13'd7; seed = 32'hFFFF_0000;
        if (dup_start) begin
            @(negedge clk);
            start = 1'b1; num_words = 13'd3;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 2000 && !run_finished; k++) @(negedge clk);
        if (!run_finished) begin
            checks++; errors++;
            $display("FAIL run_timeout actual=no_completion required=done_by_cycle_%0d", m_done_t + 1);
            m_active = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_pass"}, 32'(pass), 32'h0);
        chk({tag, "_err"}, 32'(err_count), 32'h0);
        chk({tag, "_fail"}, 32'(fail_addr), 32'h0);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'h0);
        chk({tag, "_wr"}, 32'(avm_write), 32'h0);
        chk({tag, "_addr"}, 32'(avm_address), 32'h0);
        chk({tag, "_wdata"}, avm_writedata, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        base_addr = '0; num_words = '0; seed = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic run: writes 1000..1003 to 0..3.
        run(13'h0, 13'd4, 32'h0000_1000, 1'b0);
        chk("t1_done_cycle", 32'(done_seen_t), INV ? 32'd20 : 32'd10);
        if (wd_log.size() >= 4) begin
            chk("t1_wd0", wd_log[0], 32'h1000);
            chk("t1_wd3", wd_log[3], 32'h1003);
            chk("t1_wa3", 32'(wa_log[3]), 32'h3);
        end else chk("t1_write_count", 32'(wd_log.size()), 32'd4);
        chk("t1_pass", 32'(pass), 32'h1);
        chk("t1_err", 32'(err_count), 32'h0);

        // Corrupted word at address 5, with a start pulse while busy.
        corrupt_en = 1'b1; corrupt_addr = 13'd5;
        run(13'h0, 13'd8, 32'hA5A5_0000, 1'b1);
        corrupt_en = 1'b0;
        chk("t2_pass", 32'(pass), 32'h0);
        chk("t2_err", 32'(err_count), INV ? 32'd2 : 32'd1);
        chk("t2_fail", 32'(fail_addr), 32'd5);
        chk("t2_done_cycle", 32'(done_seen_t), INV ? 32'd36 : 32'd18);

        // Address wrap at the top of the space.
        run(13'h1FFE, 13'd4, 32'hDEAD_0000, 1'b0);
        if (wa_log.size() >= 4) begin
            chk("t3_wa0", 32'(wa_log[0]), 32'h1FFE);
            chk("t3_wa1", 32'(wa_log[1]), 32'h1FFF);
            chk("t3_wa2", 32'(wa_log[2]), 32'h0000);
            chk("t3_wa3", 32'(wa_log[3]), 32'h0001);
        end else chk("t3_write_count", 32'(wa_log.size()), 32'd4);
        chk("t3_pass", 32'(pass), 32'h1);

        // Zero-length run.
        run(13'h100, 13'd0, 32'h1234_5678, 1'b0);
        chk("t4_done_cycle", 32'(done_seen_t), 32'd1);
        chk("t4_writes", 32'(wd_log.size()), 32'd0);
        chk("t4_pass", 32'(pass), 32'h1);

        // Start re-pulsed while busy must not alter run length.
        run(13'h40, 13'd6, 32'h0F0F_0F0F, 1'b1);
        chk("t5_done_cycle", 32'(done_seen_t), INV ? 32'd28 : 32'd14);

        // Reset in the middle of the read phase of a 16-word run.
        @(negedge clk);
        base_addr = 13'h200; num_words = 13'd16; seed = 32'h5555_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("t6_cs_before_reset", 32'(avm_chipselect), 32'h1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_done", 32'(done), 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_idle_done", 32'(done), 32'h0);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        run(13'h300, 13'd2, 32'h0000_00AA, 1'b0);
        chk("t6_pass", 32'(pass), 32'h1);

`ifdef MEMCHK_INVERT_PASS_EN
        // Second pass with inverted pattern.
        run(13'h0, 13'd2, 32'h0, 1'b0);
        chk("t7_done_cycle", 32'(done_seen_t), 32'd12);
        if (wd_log.size() >= 4) begin
            chk("t7_wd2", wd_log[2], 32'hFFFF_FFFF);
            chk("t7_wd3", wd_log[3], 32'hFFFF_FFFE);
        end else chk("t7_write_count", 32'(wd_log.size()), 32'd4);
        chk("t7_pass", 32'(pass), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_mem_check_master.md
NIOS_MEM_CHECK_MASTER -- requirements
Module: nios_mem_check_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (byteenable width DATA_W/8).
REQ-003 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have start  input  1  one-cycle pulse, starts a run when idle.
REQ-006 SHALL have base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-007 SHALL have num_words  input  ADDR_W  word count, sampled on accepted start.
REQ-008 SHALL have seed  input  DATA_W  pattern seed, sampled on accepted start.
REQ-009 SHALL have busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have done  output  1  one-cycle pulse at run end.
REQ-011 SHALL have pass  output  1  high when the last run had zero mismatches; held until next start.
REQ-012 SHALL have err_count  output  16  mismatch count of current/last run, saturating at 16'hFFFF.
REQ-013 SHALL have fail_addr  output  ADDR_W  address of first mismatch of the run.
REQ-014 SHALL have avm_address  output  ADDR_W; avm_chipselect, avm_write, avm_clken  output  1; avm_byteenable  output  DATA_W/8; avm_writedata  output  DATA_W; avm_readdata  input  DATA_W -- Avalon-MM master to a single-port on-chip RAM slave, no waitrequest, fixed read latency 1.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, FLUSH, DONE.
REQ-016 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-017 SHALL, on accepted start with num_words==0, go to DONE directly, pass=1, err_count=0.
REQ-018 SHALL drive avm_address = (base_addr + index) mod 2^ADDR_W, index 0..num_words-1.
REQ-019 SHALL define pattern(index) = seed + index, modulo 2^DATA_W.
REQ-020 SHALL in WRITE issue one write per cycle: chipselect=1, write=1, byteenable all ones, writedata=pattern(index); after index num_words-1 go to READ.
REQ-021 SHALL in READ issue one read per cycle (chipselect=1, write=0); after index num_words-1 go to FLUSH.
REQ-022 SHALL compare avm_readdata in the cycle after each read against pattern of that read's index; FLUSH covers the final comparison, then DONE.
REQ-023 SHALL on mismatch increment err_count (saturating); the first mismatch of a run loads fail_addr.
REQ-024 SHALL hold avm_clken=1 at all times and chipselect=0 in IDLE and DONE.
REQ-025 SHALL in DONE assert done for one cycle, set pass=(err_count==0), return to IDLE.
REQ-026 SHALL clear err_count, fail_addr and pass on accepted start.
REQ-027 SHALL, for a run of N>0 words (single pass), assert done exactly 2N+2 cycles after the start cycle.

Reset
REQ-028 SHALL on reset_n low, asynchronously: state IDLE, busy=0, done=0, pass=0, err_count=0, fail_addr=0, chipselect=0, write=0, address=0, writedata=0; reset mid-run aborts without a done pulse.

Configuration
REQ-029 SHALL, when MEMCHK_INVERT_PASS_EN is defined, after the first READ/FLUSH run a second WRITE/READ/FLUSH pass with pattern ~(seed + index), errors accumulating into the same err_count/fail_addr; done at 4N+4 cycles.
REQ-030 SHALL, without MEMCHK_INVERT_PASS_EN, perform the single pass only, with no second-pass logic synthesized.

Structure
REQ-031 SHALL place the FSM state enum and the ERR_MAX constant (16'hFFFF) in shared package nios_memchk_pkg.
REQ-032 SHALL use one sub-module, nios_memchk_cmp: registered expected-data/compare stage with saturating error counter.

Verification
REQ-033 SHALL cover: base=0, N=4, seed=32'h1000, ideal RAM model -> writes 1000..1003 at addr 0..3, done at cycle 10, pass=1, err_count=0.
REQ-034 SHALL cover: N=8, RAM model corrupts addr 5 (bit 0 flipped) -> pass=0, err_count=1, fail_addr=5.
REQ-035 SHALL cover: base=13'h1FFE, N=4 -> addresses 1FFE, 1FFF, 0000, 0001; pass=1.
REQ-036 SHALL cover: N=0 -> done within 2 cycles of start, no chipselect, pass=1; start pulsed while busy -> ignored, run length unchanged.
REQ-037 SHALL cover: reset_n dropped mid-READ of N=16 -> all outputs at reset values immediately, no done; a following run (N=2) -> pass=1.
REQ-038 SHALL cover, with MEMCHK_INVERT_PASS_EN: N=2, seed=0 -> second-pass writes FFFFFFFF, FFFFFFFE, done at cycle 12, pass=1.
